pc_sequencer: RTL and testbench

Parametrised program-counter sequencer: the successor to the fixed 8-bit `program_counter`. It holds the current instruction address and computes the next one every cycle from a prioritised set of redirects: sequential increment, PC-relative branch, absolute jump, call and return. An internal return-address stack (RAS) services call and return. It sits at the head of the fetch stage, drives instruction memory, and takes its redirect controls from decode/execute.

---
 rtl/pc_pkg.sv | 18 +
 rtl/return_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default parameter values for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH   = 8;
  localparam int unsigned DEFAULT_RESET_VECTOR = 0;
  localparam int unsigned DEFAULT_INCREMENT    = 1;
  localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET,
    SEL_HOLD
  } next_pc_sel_t;

endpackage

// File: rtl/return_stack.sv
// Circular LIFO return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  // ptr is the next free slot; once wrapped it also addresses the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full;
      if (push) begin
        ptr <= ptr + PTR_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr   <= ptr - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) entries[ptr] <= push_data;
  end

  assign top   = entries[ptr - PTR_W'(1)];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection with an internal return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int unsigned            INCREMENT    = DEFAULT_INCREMENT,
  parameter int unsigned            RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic                  call,
  input  logic                  ret,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [ADDR_WIDTH-1:0] return_address,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_overflow,
  output logic                  ras_underflow
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INCREMENT);

  next_pc_sel_t          sel;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  ras_push;
  logic                  ras_pop;

  always_comb begin
    sel = SEL_SEQ;
    if (stall)             sel = SEL_HOLD;
    else if (ret)          sel = SEL_RET;
    else if (call)         sel = SEL_CALL;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
  end

  assign return_address = pc + INC;

  // Offset is already ADDR_WIDTH wide, so modulo-2^W addition is the sign extension.
  always_comb begin
    next_pc = return_address;
    unique case (sel)
      SEL_HOLD:   next_pc = pc;
      SEL_RET:    next_pc = ras_empty ? return_address : ras_top;
      SEL_CALL:   next_pc = jump_target;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = return_address + branch_offset;
      default:    next_pc = return_address;
    endcase
  end

  assign ras_push = (sel == SEL_CALL);
  assign ras_pop  = (sel == SEL_RET) && !ras_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= next_pc;
      ras_underflow <= (sel == SEL_RET) && ras_empty;
    end
  end

  assign instruction_address = pc;

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (return_address),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (ADDR_WIDTH=8, INCREMENT=1, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       jump;
  logic       call;
  logic       ret;
  logic [7:0] jump_target;
  logic [7:0] instruction_address;
  logic [7:0] return_address;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_overflow;
  logic       ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_WIDTH   (8),
    .RESET_VECTOR (8'h00),
    .INCREMENT    (1),
    .RAS_DEPTH    (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_offset       (branch_offset),
    .jump                (jump),
    .call                (call),
    .ret                 (ret),
    .jump_target         (jump_target),
    .instruction_address (instruction_address),
    .return_address      (return_address),
    .ras_empty           (ras_empty),
    .ras_full            (ras_full),
    .ras_overflow        (ras_overflow),
    .ras_underflow       (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_controls();
    reset = 0; stall = 0; branch_taken = 0; branch_offset = '0;
    jump = 0; call = 0; ret = 0; jump_target = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    checks++; if (instruction_address !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", instruction_address); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", ras_full); end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {ras_overflow, ras_underflow}); end
    checks++; if (return_address !== 8'h01) begin errors++; $display("FAIL reset_retaddr: got %h expected 01", return_address); end
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (instruction_address !== 8'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, instruction_address, 8'(i)); end
    end
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 8'hFE;
    step();
    checks++; if (instruction_address !== 8'hFE) begin errors++; $display("FAIL jump_fe: got %h expected fe", instruction_address); end
    jump = 0;
    step();
    checks++; if (instruction_address !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h expected ff", instruction_address); end
    checks++; if (return_address !== 8'h00) begin errors++; $display("FAIL wrap_retaddr: got %h expected 00", return_address); end
    step();
    checks++; if (instruction_address !== 8'h00) begin errors++; $display("FAIL wrap_00: got %h expected 00", instruction_address); end
  endtask

  task automatic test_branch_stall();
    jump = 1; jump_target = 8'h10;
    step();
    jump = 0; branch_taken = 1; branch_offset = 8'hFC;
    step();
    checks++; if (instruction_address !== 8'h0D) begin errors++; $display("FAIL branch_back: got %h expected 0d", instruction_address); end
    branch_taken = 0; jump = 1; jump_target = 8'h10;
    step();
    jump = 0; stall = 1; branch_taken = 1; branch_offset = 8'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instruction_address !== 8'h10) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected 10", i, instruction_address); end
    end
    stall = 0;
    step();
    checks++; if (instruction_address !== 8'h31) begin errors++; $display("FAIL branch_fwd: got %h expected 31", instruction_address); end
    branch_taken = 0;
  endtask

  task automatic test_call_ret();
    jump = 1; jump_target = 8'h20;
    step();
    jump = 0; call = 1; jump_target = 8'h80;
    step();
    checks++; if (instruction_address !== 8'h80) begin errors++; $display("FAIL call_pc: got %h expected 80", instruction_address); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty: got %b expected 0", ras_empty); end
    call = 0;
    repeat (5) step();
    checks++; if (instruction_address !== 8'h85) begin errors++; $display("FAIL idle_85: got %h expected 85", instruction_address); end
    ret = 1;
    step();
    checks++; if (instruction_address !== 8'h21) begin errors++; $display("FAIL ret_pc: got %h expected 21", instruction_address); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL ret_no_underflow: got %b expected 0", ras_underflow); end
    ret = 0;
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h41, 8'h31, 8'h21, 8'h11};
    reset = 1;
    step();
    reset = 0;
    call = 1;
    for (int i = 1; i <= 5; i++) begin
      jump_target = 8'(i * 16);
      step();
      checks++; if (instruction_address !== 8'(i * 16)) begin errors++; $display("FAIL call_chain_pc[%0d]: got %h expected %h", i, instruction_address, 8'(i * 16)); end
      checks++; if (ras_full !== (i >= 4)) begin errors++; $display("FAIL call_chain_full[%0d]: got %b expected %b", i, ras_full, i >= 4); end
      checks++; if (ras_overflow !== (i == 5)) begin errors++; $display("FAIL call_chain_ovf[%0d]: got %b expected %b", i, ras_overflow, i == 5); end
    end
    call = 0; ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (instruction_address !== exp_ret[i]) begin errors++; $display("FAIL lifo_pc[%0d]: got %h expected %h", i, instruction_address, exp_ret[i]); end
      checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear[%0d]: got %b expected 0", i, ras_overflow); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL lifo_empty: got %b expected 1", ras_empty); end
    step();
    checks++; if (instruction_address !== 8'h12) begin errors++; $display("FAIL underflow_pc: got %h expected 12", instruction_address); end
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got %b expected 1", ras_underflow); end
    ret = 0;
    step();
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", ras_underflow); end
    checks++; if (instruction_address !== 8'h13) begin errors++; $display("FAIL after_underflow_pc: got %h expected 13", instruction_address); end
  endtask

  task automatic test_priority();
    jump = 1; jump_target = 8'h40;
    step();
    jump = 0; call = 1; jump_target = 8'h60;
    step();
    ret = 1; call = 1; jump = 1; branch_taken = 1; jump_target = 8'h90; branch_offset = 8'h05;
    step();
    checks++; if (instruction_address !== 8'h41) begin errors++; $display("FAIL priority_pc: got %h expected 41", instruction_address); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL priority_no_push: got %b expected 1", ras_empty); end
    clear_controls();
  endtask

  task automatic test_reset_mid();
    call = 1; jump_target = 8'h70;
    step();
    jump_target = 8'h75;
    step();
    call = 0;
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL mid_preload: got %b expected 0", ras_empty); end
    reset = 1; ret = 1;
    step();
    checks++; if (instruction_address !== 8'h00) begin errors++; $display("FAIL mid_reset_pc: got %h expected 00", instruction_address); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL mid_reset_pulse: got %b expected 0", ras_underflow); end
    reset = 0;
    step();
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL mid_ret_underflow: got %b expected 1", ras_underflow); end
    checks++; if (instruction_address !== 8'h01) begin errors++; $display("FAIL mid_ret_pc: got %h expected 01", instruction_address); end
    ret = 0;
  endtask

  initial begin
    clear_controls();
    test_reset();
    test_wrap();
    test_branch_stall();
    test_call_ret();
    test_overflow_underflow();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
